// File: rtl/aes_byte_loader.sv
// Byte-serial front end for the AES core: assembles header/key/data frames,
// launches one AES operation per frame and waits for completion.
module aes_byte_loader #(
    parameter int BYTE_TIMEOUT = 1000,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic [7:0]   i_Byte,
    input  logic         i_fByteValid,
    output logic         o_fReady,
    output logic [127:0] o_Key,
    output logic [127:0] o_Data,
    output logic         o_fEncrypt,
    output logic         o_fStart,
    input  logic         i_fDone,
    output logic         o_fErr
);

    localparam int MAX_TMO = (BYTE_TIMEOUT > DONE_TIMEOUT) ? BYTE_TIMEOUT : DONE_TIMEOUT;
    localparam int TW      = (MAX_TMO > 1) ? $clog2(MAX_TMO) : 1;
    localparam logic [TW-1:0] BYTE_LAST = TW'(BYTE_TIMEOUT - 1);
    localparam logic [TW-1:0] DONE_LAST = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_DATA,
        S_START,
        S_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [127:0]    r_key_stg;
    logic [127:0]    r_data_stg;
    logic [3:0]      r_cnt;
    logic [TW-1:0]   r_tmo;
    logic            r_key_valid;
    logic            r_enc_hdr;
    logic            r_err;
    logic            w_accept;
    logic            w_hdr_ok;
    logic            w_last_byte;
    logic            w_byte_tmo;
    logic            w_err;

    assign w_accept    = i_fByteValid && o_fReady;
    assign w_hdr_ok    = (i_Byte[7:2] == 6'd0);
    assign w_last_byte = (r_cnt == 4'd15);
    assign w_byte_tmo  = (r_tmo == BYTE_LAST);
    assign o_fErr      = r_err;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_hdr_ok && i_Byte[1]) begin
                        w_state_next = S_KEY;
                    end else if (w_hdr_ok && r_key_valid) begin
                        w_state_next = S_DATA;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_KEY: begin
                if (w_accept) begin
                    if (w_last_byte) begin
                        w_state_next = S_DATA;
                    end
                end else if (w_byte_tmo) begin
                    w_state_next = S_IDLE;
                    w_err        = 1'b1;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (w_last_byte) begin
                        w_state_next = S_START;
                    end
                end else if (w_byte_tmo) begin
                    w_state_next = S_IDLE;
                    w_err        = 1'b1;
                end
            end
            S_START: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_fDone) begin
                    w_state_next = S_IDLE;
                end else if (r_tmo == DONE_LAST) begin
                    w_state_next = S_IDLE;
                    w_err        = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Ready is gated by reset so the feeder sees 0 for the whole reset window.
    always_comb begin
        o_fStart = (r_state == S_START);
        o_fReady = Rst && ((r_state == S_IDLE) || (r_state == S_KEY) || (r_state == S_DATA));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            o_Key       <= '0;
            o_Data      <= '0;
            o_fEncrypt  <= 1'b0;
            r_key_stg   <= '0;
            r_data_stg  <= '0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_key_valid <= 1'b0;
            r_enc_hdr   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_err;

            // One counter serves both the inter-byte and the AES-done timeouts.
            if (w_accept || (w_state_next != r_state) || (r_state == S_IDLE)) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_state_next != S_IDLE) begin
                        r_enc_hdr <= i_Byte[0];
                    end
                end
                S_KEY: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_last_byte) begin
                            o_Key       <= {r_key_stg[119:0], i_Byte};
                            r_key_valid <= 1'b1;
                            r_key_stg   <= '0;
                        end else begin
                            r_key_stg <= {r_key_stg[119:0], i_Byte};
                        end
                    end else if (w_byte_tmo) begin
                        r_key_stg <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_last_byte) begin
                            o_Data     <= {r_data_stg[119:0], i_Byte};
                            o_fEncrypt <= r_enc_hdr;
                            r_data_stg <= '0;
                        end else begin
                            r_data_stg <= {r_data_stg[119:0], i_Byte};
                        end
                    end else if (w_byte_tmo) begin
                        r_data_stg <= '0;
                        r_cnt      <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_byte_loader.sv
// Self-checking bench for aes_byte_loader: vector table, random frames against a
// frame-level model, and hand sequences for timeouts and mid-frame reset.
module tb_aes_byte_loader;

    localparam int BT = 1000;
    localparam int DT = 4096;

    localparam logic [127:0] KA = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] DA = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] DB = 128'h29C3505F571420F6402299B31A02D73A;
    localparam logic [127:0] KB = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] DC = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] KC = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] DD = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] DE = 128'h6BC1BEE22E409F96E93D7E117393172A;
    localparam logic [127:0] KD = 128'h603DEB1015CA71BE2B73AEF0857D7781;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic [7:0]   i_Byte = 8'h00;
    logic         i_fByteValid = 1'b0;
    logic         i_fDone = 1'b0;
    logic         o_fReady;
    logic [127:0] o_Key;
    logic [127:0] o_Data;
    logic         o_fEncrypt;
    logic         o_fStart;
    logic         o_fErr;

    always #5 Clk = ~Clk;

    aes_byte_loader #(.BYTE_TIMEOUT(BT), .DONE_TIMEOUT(DT)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .i_Byte       (i_Byte),
        .i_fByteValid (i_fByteValid),
        .o_fReady     (o_fReady),
        .o_Key        (o_Key),
        .o_Data       (o_Data),
        .o_fEncrypt   (o_fEncrypt),
        .o_fStart     (o_fStart),
        .i_fDone      (i_fDone),
        .o_fErr       (o_fErr)
    );

    int n_chk   = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_err   = 0;

    always @(negedge Clk) begin
        if (o_fStart === 1'b1) n_start++;
        if (o_fErr === 1'b1) n_err++;
    end

    // Frame-level reference state: what the AES side should currently see.
    logic [127:0] m_key  = '0;
    logic [127:0] m_data = '0;
    logic         m_enc  = 1'b0;
    logic         m_kv   = 1'b0;

    typedef struct {
        logic [7:0]   hdr;
        logic [127:0] key;
        logic [127:0] data;
        logic         exp_err;
        logic [127:0] exp_key;
        logic [127:0] exp_data;
        logic         exp_enc;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_Byte       = b;
        i_fByteValid = 1'b1;
        @(posedge Clk);
        #1;
        i_fByteValid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] v, input int nbytes, input bit gaps);
        for (int i = 15; i > 15 - nbytes; i--) begin
            if (gaps && $urandom_range(0, 7) == 0) tick($urandom_range(1, 20));
            send(v[i*8 +: 8]);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] hdr, input logic [127:0] key,
                             input logic [127:0] data, input logic exp_err,
                             input logic [127:0] exp_key, input logic [127:0] exp_data,
                             input logic exp_enc);
        int s0;
        int e0;
        s0 = n_start;
        e0 = n_err;
        send(hdr);
        if (exp_err) begin
            tick(1);
            chk({tag, " hdr err pulses"}, 128'(n_err - e0), 128'd1);
            chk({tag, " hdr no start"}, 128'(n_start - s0), 128'd0);
            chk({tag, " hdr ready"}, {127'd0, o_fReady}, 128'd1);
            chk({tag, " hdr key kept"}, o_Key, exp_key);
            chk({tag, " hdr data kept"}, o_Data, exp_data);
            return;
        end
        if (hdr[1]) send_block(key, 16, 1'b1);
        send_block(data, 16, 1'b1);
        chk({tag, " start latency"}, {127'd0, o_fStart}, 128'd1);
        chk({tag, " ready in start"}, {127'd0, o_fReady}, 128'd0);
        tick(1);
        chk({tag, " start single"}, {127'd0, o_fStart}, 128'd0);
        chk({tag, " ready in wait"}, {127'd0, o_fReady}, 128'd0);
        chk({tag, " key"}, o_Key, exp_key);
        chk({tag, " data"}, o_Data, exp_data);
        chk({tag, " encrypt"}, {127'd0, o_fEncrypt}, {127'd0, exp_enc});
        i_Byte       = 8'($urandom);
        i_fByteValid = 1'b1;
        tick($urandom_range(0, 10));
        i_fByteValid = 1'b0;
        chk({tag, " data held in wait"}, o_Data, exp_data);
        i_fDone = 1'b1;
        tick(1);
        i_fDone = 1'b0;
        chk({tag, " ready after done"}, {127'd0, o_fReady}, 128'd1);
        chk({tag, " start count"}, 128'(n_start - s0), 128'd1);
        chk({tag, " no err"}, 128'(n_err - e0), 128'd0);
    endtask

    task automatic model_frame(input string tag, input logic [7:0] hdr,
                               input logic [127:0] key, input logic [127:0] data);
        logic ok;
        ok = (hdr[7:2] == 6'd0) && (hdr[1] || m_kv);
        if (ok) begin
            if (hdr[1]) begin
                m_key = key;
                m_kv  = 1'b1;
            end
            m_data = data;
            m_enc  = hdr[0];
        end
        run_frame(tag, hdr, key, data, !ok, m_key, m_data, m_enc);
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        tick(2);
        Rst = 1'b1;
        #1;
        m_key = '0; m_data = '0; m_enc = 1'b0; m_kv = 1'b0;
    endtask

    initial begin
        int e0;
        int s0;
        logic [7:0]   hdr;
        logic [127:0] rk;
        logic [127:0] rd;

        tbl[0] = '{hdr: 8'h03, key: KA, data: DA, exp_err: 1'b0, exp_key: KA, exp_data: DA, exp_enc: 1'b1};
        tbl[1] = '{hdr: 8'h00, key: '0, data: DB, exp_err: 1'b0, exp_key: KA, exp_data: DB, exp_enc: 1'b0};
        tbl[2] = '{hdr: 8'h84, key: '0, data: '0, exp_err: 1'b1, exp_key: KA, exp_data: DB, exp_enc: 1'b0};
        tbl[3] = '{hdr: 8'h02, key: KB, data: DC, exp_err: 1'b0, exp_key: KB, exp_data: DC, exp_enc: 1'b0};
        tbl[4] = '{hdr: 8'h05, key: '0, data: '0, exp_err: 1'b1, exp_key: KB, exp_data: DC, exp_enc: 1'b0};
        tbl[5] = '{hdr: 8'h01, key: '0, data: DA, exp_err: 1'b0, exp_key: KB, exp_data: DA, exp_enc: 1'b1};

        // Reset state
        @(posedge Clk);
        #1;
        tick(2);
        chk("reset ready", {127'd0, o_fReady}, 128'd0);
        chk("reset key", o_Key, 128'd0);
        chk("reset data", o_Data, 128'd0);
        chk("reset start/err/enc", {125'd0, o_fStart, o_fErr, o_fEncrypt}, 128'd0);
        Rst = 1'b1;
        #1;
        chk("ready after release", {127'd0, o_fReady}, 128'd1);
        tick(1);

        // No key loaded yet, then a header with reserved bits set
        run_frame("nokey 01", 8'h01, '0, '0, 1'b1, 128'd0, 128'd0, 1'b0);
        run_frame("bad 84", 8'h84, '0, '0, 1'b1, 128'd0, 128'd0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].hdr, tbl[i].key, tbl[i].data,
                      tbl[i].exp_err, tbl[i].exp_key, tbl[i].exp_data, tbl[i].exp_enc);
        end
        m_key = KB; m_data = DA; m_enc = 1'b1; m_kv = 1'b1;

        for (int i = 0; i < 16; i++) begin
            hdr = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            rk  = {$urandom, $urandom, $urandom, $urandom};
            rd  = {$urandom, $urandom, $urandom, $urandom};
            model_frame($sformatf("rnd%0d h=%h", i, hdr), hdr, rk, rd);
        end

        // Byte timeout in the data phase after a completed key
        e0 = n_err;
        s0 = n_start;
        send(8'h03);
        send_block(KC, 16, 1'b0);
        send_block(DD, 5, 1'b0);
        tick(BT - 1);
        chk("btmo not early", {127'd0, o_fErr}, 128'd0);
        tick(1);
        chk("btmo err pulse", {127'd0, o_fErr}, 128'd1);
        tick(1);
        chk("btmo err count", 128'(n_err - e0), 128'd1);
        chk("btmo no start", 128'(n_start - s0), 128'd0);
        chk("btmo key committed", o_Key, KC);
        chk("btmo data kept", o_Data, m_data);
        chk("btmo ready", {127'd0, o_fReady}, 128'd1);
        m_key = KC;
        model_frame("after btmo", 8'h00, '0, DD);

        // Done timeout, with bytes offered while waiting
        e0 = n_err;
        send(8'h01);
        send_block(DE, 16, 1'b0);
        m_data = DE; m_enc = 1'b1;
        chk("dtmo start", {127'd0, o_fStart}, 128'd1);
        i_Byte = 8'h03;
        i_fByteValid = 1'b1;
        tick(30);
        i_fByteValid = 1'b0;
        chk("dtmo ready low", {127'd0, o_fReady}, 128'd0);
        tick(DT - 30);
        chk("dtmo not early", {127'd0, o_fErr}, 128'd0);
        tick(1);
        chk("dtmo err pulse", {127'd0, o_fErr}, 128'd1);
        chk("dtmo ready", {127'd0, o_fReady}, 128'd1);
        chk("dtmo data held", o_Data, DE);
        tick(1);
        chk("dtmo err count", 128'(n_err - e0), 128'd1);
        model_frame("after dtmo", 8'h02, KB, DC);

        // Asynchronous reset in the middle of a key
        send(8'h03);
        send_block(KD, 10, 1'b0);
        #2;
        Rst = 1'b0;
        #1;
        chk("mid rst key", o_Key, 128'd0);
        chk("mid rst data", o_Data, 128'd0);
        chk("mid rst flags", {124'd0, o_fReady, o_fStart, o_fErr, o_fEncrypt}, 128'd0);
        tick(2);
        Rst = 1'b1;
        #1;
        m_key = '0; m_data = '0; m_enc = 1'b0; m_kv = 1'b0;
        model_frame("post rst nokey", 8'h00, '0, DA);
        model_frame("post rst full", 8'h03, KD, DA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
